ysyx_22050854_wb_arbiter: RTL and testbench

Shares the single write port of the NPC integer register file between two writeback requesters: the execute unit (EXU) and the load/store unit (LSU). Each requester uses a valid/ready handshake; the arbiter registers the winner into a one-stage write buffer that drives the register file write port. A 32-entry pending-write scoreboard tells decode which destination registers still have writes in flight.

---
 rtl/ysyx_22050854_pkg.sv | 34 +++
 rtl/ysyx_22050854_wb_scoreboard.sv | 51 +++++
 rtl/ysyx_22050854_wb_arbiter.sv | 147 ++++++++++++++
 tb/tb_ysyx_22050854_wb_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050854_pkg.sv
// ============================================================================
// Module      : ysyx_22050854_pkg
// Description : Shared constants and types for the NPC writeback path:
//               data width, register-index width and the writeback request
//               record carried from a requester into the write buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package ysyx_22050854_pkg;

  // Integer register file data width.
  localparam int XLEN     = 64;
  // Register-index width (x0..x31).
  localparam int REG_AW   = 5;
  // Number of architectural integer registers.
  localparam int NUM_REGS = 1 << REG_AW;

  // One writeback request: valid flag, destination register, result data.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  // One-hot mask selecting register rd.
  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_AW-1:0] rd);
    return NUM_REGS'(1) << rd;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_22050854_wb_scoreboard.sv
// ============================================================================
// Module      : ysyx_22050854_wb_scoreboard
// Description : 32-entry pending-write scoreboard. One set port (decode issue)
//               and one clear port (register file write). A set and a clear
//               of the same register in one cycle leave the bit set, because
//               the newly issued write is still outstanding. Bit 0 (x0) is
//               never set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module ysyx_22050854_wb_scoreboard
  import ysyx_22050854_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                set_en_i,
  input  logic [REG_AW-1:0]   set_idx_i,
  input  logic                clr_en_i,
  input  logic [REG_AW-1:0]   clr_idx_i,
  output logic [NUM_REGS-1:0] pending_o
);

  logic [NUM_REGS-1:0] pend_q;
  logic [NUM_REGS-1:0] pend_d;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  // Next state: clear first, then OR in the set so that set wins on a tie.
  always_comb begin
    set_mask = set_en_i ? rd_onehot(set_idx_i) : '0;
    clr_mask = clr_en_i ? rd_onehot(clr_idx_i) : '0;
    pend_d   = (pend_q & ~clr_mask) | set_mask;
    pend_d[0] = 1'b0;
  end

  // Scoreboard register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pending_o = pend_q;

endmodule

`default_nettype wire

// File: rtl/ysyx_22050854_wb_arbiter.sv
// ============================================================================
// Module      : ysyx_22050854_wb_arbiter
// Description : Shares the single integer register file write port between
//               the EXU and LSU writeback requesters. LSU has fixed priority;
//               EXU is forced through after STARVE_LIMIT consecutive lost
//               cycles. The winner is captured in a one-stage write buffer
//               that drives the register file one cycle after the grant.
//               A pending-write scoreboard tracks in-flight destinations.
//               Optional bypass outputs: define YSYX_22050854_WB_FWD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module ysyx_22050854_wb_arbiter
  import ysyx_22050854_pkg::*;
#(
  // Must match the package data width; the write buffer uses the package type.
  parameter int XLEN         = ysyx_22050854_pkg::XLEN,
  // Consecutive lost EXU cycles before EXU is forced to win (1..15).
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                exu_valid,
  output logic                exu_ready,
  input  logic [REG_AW-1:0]   exu_rd,
  input  logic [XLEN-1:0]     exu_data,

  input  logic                lsu_valid,
  output logic                lsu_ready,
  input  logic [REG_AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0]     lsu_data,

  input  logic                issue_valid,
  input  logic [REG_AW-1:0]   issue_rd,

  output logic                rf_wen,
  output logic [REG_AW-1:0]   rf_waddr,
  output logic [XLEN-1:0]     rf_wdata,

`ifdef YSYX_22050854_WB_FWD_EN
  output logic                fwd_valid,
  output logic [REG_AW-1:0]   fwd_rd,
  output logic [XLEN-1:0]     fwd_data,
`endif

  output logic [NUM_REGS-1:0] pending
);

  localparam logic [3:0] STARVE_LIMIT_4B = 4'(STARVE_LIMIT);

  wb_req_t    exu_req;
  wb_req_t    lsu_req;
  wb_req_t    win_req;
  wb_req_t    wb_q;
  wb_req_t    wb_d;
  logic [3:0] starve_q;
  logic [3:0] starve_d;
  logic       exu_force;
  logic       exu_grant;
  logic       lsu_grant;
  logic       issue_set;

  assign exu_req = '{valid: exu_valid, rd: exu_rd, data: exu_data};
  assign lsu_req = '{valid: lsu_valid, rd: lsu_rd, data: lsu_data};

  // Grant selection: LSU first unless EXU has hit its starvation limit;
  // nothing is granted while reset is asserted.
  always_comb begin
    exu_force = (starve_q == STARVE_LIMIT_4B);
    exu_grant = 1'b0;
    lsu_grant = 1'b0;
    if (!rst) begin
      if (exu_req.valid && (!lsu_req.valid || exu_force)) begin
        exu_grant = 1'b1;
      end else if (lsu_req.valid) begin
        lsu_grant = 1'b1;
      end
    end
  end

  assign exu_ready = exu_grant;
  assign lsu_ready = lsu_grant;

  // Starvation counter: counts consecutive cycles EXU waits, saturating at
  // the limit so the force condition stays true until EXU is served.
  always_comb begin
    starve_d = starve_q;
    if (!exu_req.valid || exu_grant) begin
      starve_d = '0;
    end else if (starve_q != STARVE_LIMIT_4B) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // Write buffer next state: load the winner on a grant; an x0 transfer is
  // accepted but does not raise the write enable. Address/data hold when idle.
  always_comb begin
    win_req    = exu_grant ? exu_req : lsu_req;
    wb_d       = wb_q;
    wb_d.valid = 1'b0;
    if (exu_grant || lsu_grant) begin
      wb_d.valid = (win_req.rd != '0);
      wb_d.rd    = win_req.rd;
      wb_d.data  = win_req.data;
    end
  end

  // Arbiter and write buffer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
      wb_q     <= '0;
    end else begin
      starve_q <= starve_d;
      wb_q     <= wb_d;
    end
  end

  assign rf_wen   = wb_q.valid;
  assign rf_waddr = wb_q.rd;
  assign rf_wdata = wb_q.data;

`ifdef YSYX_22050854_WB_FWD_EN
  // Bypass view of the buffered write; valid already excludes x0.
  assign fwd_valid = wb_q.valid;
  assign fwd_rd    = wb_q.rd;
  assign fwd_data  = wb_q.data;
`endif

  assign issue_set = issue_valid && (issue_rd != '0);

  ysyx_22050854_wb_scoreboard u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_en_i  (issue_set),
    .set_idx_i (issue_rd),
    .clr_en_i  (wb_q.valid),
    .clr_idx_i (wb_q.rd),
    .pending_o (pending)
  );

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22050854_wb_arbiter.sv
// ============================================================================
// Module      : tb_ysyx_22050854_wb_arbiter
// Description : Directed self-checking bench for the writeback arbiter.
//               Expected register file writes are queued when requests are
//               driven and compared whenever the write port fires.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ysyx_22050854_wb_arbiter;

  localparam int XLEN = 64;

  logic            clk;
  logic            rst;
  logic            exu_valid;
  logic            exu_ready;
  logic [4:0]      exu_rd;
  logic [XLEN-1:0] exu_data;
  logic            lsu_valid;
  logic            lsu_ready;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic            rf_wen;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [31:0]     pending;
`ifdef YSYX_22050854_WB_FWD_EN
  logic            fwd_valid;
  logic [4:0]      fwd_rd;
  logic [XLEN-1:0] fwd_data;
`endif

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } exp_wr_t;

  exp_wr_t exp_q[$];
  int      n_assert = 0;
  int      n_fail   = 0;

  ysyx_22050854_wb_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .exu_valid   (exu_valid),
    .exu_ready   (exu_ready),
    .exu_rd      (exu_rd),
    .exu_data    (exu_data),
    .lsu_valid   (lsu_valid),
    .lsu_ready   (lsu_ready),
    .lsu_rd      (lsu_rd),
    .lsu_data    (lsu_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rf_wen      (rf_wen),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
`ifdef YSYX_22050854_WB_FWD_EN
    .fwd_valid   (fwd_valid),
    .fwd_rd      (fwd_rd),
    .fwd_data    (fwd_data),
`endif
    .pending     (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [4:0] rd, input logic [XLEN-1:0] data);
    exp_wr_t e;
    e.rd   = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Drive point: just after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write-port monitor: every write must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && rf_wen) begin
      if (exp_q.size() == 0) begin
        chk("wb_unexpected_write_addr", {59'd0, rf_waddr}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_wr_t e;
        e = exp_q.pop_front();
        chk("wb_waddr", {59'd0, rf_waddr}, {59'd0, e.rd});
        chk("wb_wdata", rf_wdata, e.data);
      end
    end
  end

  initial begin
    rst         = 1'b1;
    exu_valid   = 1'b1;
    exu_rd      = 5'd9;
    exu_data    = 64'hAA;
    lsu_valid   = 1'b1;
    lsu_rd      = 5'd10;
    lsu_data    = 64'hBB;
    issue_valid = 1'b0;
    issue_rd    = 5'd0;

    // Reset held two cycles with both requesters asserting valid.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst_exu_ready", {63'd0, exu_ready}, 64'd0);
      chk("rst_lsu_ready", {63'd0, lsu_ready}, 64'd0);
      chk("rst_rf_wen", {63'd0, rf_wen}, 64'd0);
      chk("rst_pending", {32'd0, pending}, 64'd0);
      if (c == 0) tick();
    end
    chk("rst_rf_waddr", {59'd0, rf_waddr}, 64'd0);
    chk("rst_rf_wdata", rf_wdata, 64'd0);
    tick();
    rst       = 1'b0;
    exu_valid = 1'b0;
    lsu_valid = 1'b0;
    @(negedge clk);
    chk("idle_rf_wen", {63'd0, rf_wen}, 64'd0);

    // Simultaneous requests after issuing x5 and x6.
    tick(); issue_valid = 1'b1; issue_rd = 5'd5;
    tick(); issue_rd = 5'd6;
    tick();
    issue_valid = 1'b0;
    exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 64'h11;
    lsu_valid = 1'b1; lsu_rd = 5'd6; lsu_data = 64'h22;
    @(negedge clk);
    chk("sim_pending_set", {32'd0, pending}, 64'h60);
    chk("sim_lsu_ready", {63'd0, lsu_ready}, 64'd1);
    chk("sim_exu_ready", {63'd0, exu_ready}, 64'd0);
    push_exp(5'd6, 64'h22);
    tick(); lsu_valid = 1'b0;
    @(negedge clk);
    chk("sim2_exu_ready", {63'd0, exu_ready}, 64'd1);
    chk("sim2_lsu_ready", {63'd0, lsu_ready}, 64'd0);
    chk("sim2_pending", {32'd0, pending}, 64'h60);
    push_exp(5'd5, 64'h11);
    tick(); exu_valid = 1'b0;
    @(negedge clk);
    chk("sim3_pending", {32'd0, pending}, 64'h20);
    tick();
    @(negedge clk);
    chk("sim4_pending", {32'd0, pending}, 64'h0);

    // Starvation: both valid from cycle 0, EXU forced through in cycle 4.
    tick();
    exu_valid = 1'b1; exu_rd = 5'd2; exu_data = 64'h200;
    lsu_valid = 1'b1; lsu_rd = 5'd1;
    for (int i = 0; i < 4; i++) begin
      lsu_data = 64'h100 + 64'(i);
      @(negedge clk);
      chk("starve_lsu_ready", {63'd0, lsu_ready}, 64'd1);
      chk("starve_exu_ready", {63'd0, exu_ready}, 64'd0);
      push_exp(5'd1, 64'h100 + 64'(i));
      tick();
    end
    lsu_data = 64'h104;
    @(negedge clk);
    chk("starve4_exu_ready", {63'd0, exu_ready}, 64'd1);
    chk("starve4_lsu_ready", {63'd0, lsu_ready}, 64'd0);
    push_exp(5'd2, 64'h200);
    tick(); exu_valid = 1'b0;
    @(negedge clk);
    chk("starve5_lsu_ready", {63'd0, lsu_ready}, 64'd1);
    push_exp(5'd1, 64'h104);
    tick(); lsu_valid = 1'b0;
    tick();

    // x0 write: accepted, never reaches the register file.
    exu_valid = 1'b1; exu_rd = 5'd0; exu_data = 64'hFF;
    @(negedge clk);
    chk("x0_exu_ready", {63'd0, exu_ready}, 64'd1);
    tick(); exu_valid = 1'b0;
    @(negedge clk);
    chk("x0_rf_wen", {63'd0, rf_wen}, 64'd0);
    chk("x0_pending", {32'd0, pending}, 64'd0);

    // Scoreboard race: re-issue x7 in the cycle x7 is written.
    tick(); issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    issue_valid = 1'b0;
    exu_valid = 1'b1; exu_rd = 5'd7; exu_data = 64'h77;
    @(negedge clk);
    chk("race_pending_set", {32'd0, pending}, 64'h80);
    chk("race_exu_ready", {63'd0, exu_ready}, 64'd1);
    push_exp(5'd7, 64'h77);
    tick();
    exu_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd7;
    @(negedge clk);
    chk("race_rf_wen", {63'd0, rf_wen}, 64'd1);
    tick(); issue_valid = 1'b0;
    @(negedge clk);
    chk("race_pending_kept", {32'd0, pending}, 64'h80);
    tick();
    exu_valid = 1'b1; exu_rd = 5'd7; exu_data = 64'h78;
    @(negedge clk);
    push_exp(5'd7, 64'h78);
    tick(); exu_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("race_pending_clear", {32'd0, pending}, 64'h0);

    // Reset mid-transfer: LSU granted, reset in the following cycle.
    tick(); issue_valid = 1'b1; issue_rd = 5'd3;
    tick();
    issue_valid = 1'b0;
    lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 64'h33;
    @(negedge clk);
    chk("mid_lsu_ready", {63'd0, lsu_ready}, 64'd1);
    chk("mid_pending", {32'd0, pending}, 64'h08);
    tick(); lsu_valid = 1'b0; rst = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("mid_rf_wen", {63'd0, rf_wen}, 64'd0);
    chk("mid_pending_clr", {32'd0, pending}, 64'd0);
    chk("mid_rf_waddr", {59'd0, rf_waddr}, 64'd0);
    chk("mid_rf_wdata", rf_wdata, 64'd0);

    tick();
    tick();
    chk("exp_queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
